// File: rtl/fir_sample_feeder.sv
// Input stage for the 64-tap FIR core: buffers valid/ready samples in a circular store
// and issues one FRAME_LEN-beat write burst per frame when the core can accept it.
//   state      | meaning
//   IDLE       | buffering; waiting for a full frame and a clean able2write
//   BURST      | one pop and one core write per cycle, FRAME_LEN beats
//   HOLD       | burst issued; waiting for the core's able2write to drop
//   WAIT_EMPTY | waiting for able2write to return (frame consumed by core)
module fir_sample_feeder #(
    parameter  int DATA_W    = 16,
    parameter  int FRAME_LEN = 64,
    parameter  int BUF_DEPTH = 128,
    parameter  int CNT_W     = 16,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk1,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              able2write,
    output logic [DATA_W-1:0] core_data,
    output logic              core_wr,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [LVL_W-1:0]  buf_level
);

    localparam int             BEAT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BURST      = 2'd1,
        HOLD       = 2'd2,
        WAIT_EMPTY = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [DATA_W-1:0]   core_data_q, core_data_d;
    logic                core_wr_q, core_wr_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]   mem_q [BUF_DEPTH];
    logic                push, pop, a2w_hi;

    // able2write can be X while the core leaves reset; only a clean 1 counts as high.
    assign a2w_hi  = (able2write === 1'b1);
    assign s_ready = (level_q != FULL_LVL);
    assign push    = s_valid && s_ready;
    assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem_q[wptr_q] <= s_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        beats_d     = beats_q;
        pop         = 1'b0;
        core_wr_d   = 1'b0;
        core_data_d = core_data_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (level_q >= FRAME_LVL && a2w_hi) begin
                    state_d = BURST;
                    beats_d = BEAT_W'(FRAME_LEN - 1);
                end
            end
            BURST: begin
                pop         = 1'b1;
                core_wr_d   = 1'b1;
                core_data_d = mem_q[rptr_q];
                if (beats_q == '0) begin
                    state_d     = HOLD;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end else begin
                    beats_d = beats_q - BEAT_W'(1);
                end
            end
            HOLD: begin
                if (!a2w_hi) begin
                    state_d = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (a2w_hi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            beats_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            core_data_q <= '0;
            core_wr_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            level_q     <= level_d;
            core_data_q <= core_data_d;
            core_wr_q   <= core_wr_d;
            frame_cnt_q <= frame_cnt_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    assign core_data = core_data_q;
    assign core_wr   = core_wr_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;
    assign buf_level = level_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: vector table for frame-level steps, hand-written
// sequences for latency, hold-off, continuous streaming and mid-burst reset.
module tb_fir_sample_feeder;

    localparam int FRAME_LEN = 64;
    localparam int CNT_W     = 16;
    localparam int LVL_W     = 8;

    logic             clk1 = 1'b0;
    logic             rstn = 1'b0;
    logic [15:0]      s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             able2write = 1'b0;
    logic [15:0]      core_data;
    logic             core_wr;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic [LVL_W-1:0] buf_level;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_total = 0;
    int          run_len = 0;
    logic [15:0] model_q[$];
    logic [15:0] next_val = '0;
    logic        push_done = 1'b0;

    typedef struct {
        logic [8*12-1:0] name;
        int   n_push;
        logic a2w;
        int   settle;
        logic rel;
        int   e_acc;
        int   e_lvl;
        logic e_rdy;
        logic e_busy;
        int   e_wr;
        int   e_frames;
    } vec_t;

    vec_t vecs[5];

    always #5 clk1 = ~clk1;

    fir_sample_feeder dut (
        .clk1       (clk1),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .able2write (able2write),
        .core_data  (core_data),
        .core_wr    (core_wr),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .buf_level  (buf_level)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [15:0] exp_d;
        forever begin
            @(negedge clk1);
            if (!rstn) begin
                run_len = 0;
                model_q.delete();
            end else if (core_wr === 1'b1) begin
                wr_total++;
                run_len++;
                if (model_q.size() == 0) begin
                    check("core_wr_without_sample", 1, 0);
                end else begin
                    exp_d = model_q.pop_front();
                    check("core_data_order", core_data, exp_d);
                end
                check("s_ready_in_burst", s_ready, 1);
            end else if (run_len != 0) begin
                check("burst_len", run_len, FRAME_LEN);
                run_len = 0;
            end
        end
    endtask

    task automatic push_n(input int n, input int budget, output int acc);
        int   cyc;
        logic rdy;
        cyc = 0;
        acc = 0;
        while (acc < n && cyc < budget) begin
            s_data  = next_val;
            s_valid = 1'b1;
            rdy     = s_ready;
            @(posedge clk1);
            if (rdy) begin
                model_q.push_back(next_val);
                next_val++;
                acc++;
            end
            @(negedge clk1);
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic release_core();
        able2write = 1'b0;
        repeat (2) @(negedge clk1);
        able2write = 1'b1;
        repeat (2) @(negedge clk1);
    endtask

    task automatic wait_wr(input int limit, output int k);
        k = 0;
        while (core_wr !== 1'b1 && k < limit) begin
            @(negedge clk1);
            k++;
        end
    endtask

    task automatic run_vec(input int i);
        int acc, wr0;
        vec_t v;
        v   = vecs[i];
        wr0 = wr_total;
        able2write = v.a2w;
        push_n(v.n_push, v.n_push + 20, acc);
        repeat (v.settle) @(negedge clk1);
        check($sformatf("%s_acc", v.name), acc, v.e_acc);
        check($sformatf("%s_level", v.name), buf_level, v.e_lvl);
        check($sformatf("%s_ready", v.name), s_ready, v.e_rdy);
        check($sformatf("%s_busy", v.name), busy, v.e_busy);
        check($sformatf("%s_wr", v.name), wr_total - wr0, v.e_wr);
        check($sformatf("%s_frames", v.name), frame_cnt, v.e_frames);
        if (v.rel) begin
            release_core();
            check($sformatf("%s_idle", v.name), busy, 0);
        end
    endtask

    task automatic auto_core(input int budget);
        logic [CNT_W-1:0] last;
        int cyc;
        cyc  = 0;
        last = frame_cnt;
        while (!(push_done && !busy && buf_level < LVL_W'(FRAME_LEN)) && cyc < budget) begin
            @(negedge clk1);
            cyc++;
            if (frame_cnt != last) begin
                last = frame_cnt;
                able2write = 1'b0;
                repeat (3) @(negedge clk1);
                able2write = 1'b1;
                cyc += 3;
            end
        end
        check("t5_drain_in_time", cyc < budget, 1);
    endtask

    initial begin
        int acc, k, wr0, beats;
        vecs[0] = '{"t1_frame",  64, 1'b1, 70, 1'b1, 64,   0, 1'b1, 1'b1, 64, 1};
        vecs[1] = '{"t2_63",     63, 1'b1, 10, 1'b0, 63,  63, 1'b1, 1'b0,  0, 1};
        vecs[2] = '{"t3_fill",  129, 1'bx,  4, 1'b0, 128, 128, 1'b0, 1'b0,  0, 2};
        vecs[3] = '{"t3_burst",   0, 1'b1, 68, 1'b0,  0,  64, 1'b1, 1'b1, 64, 3};
        vecs[4] = '{"t6_recover", 64, 1'b1, 70, 1'b1, 64,  0, 1'b1, 1'b1, 64, 1};

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk1);
        rstn = 1'b1;
        @(negedge clk1);
        check("rst_core_wr", core_wr, 0);
        check("rst_core_data", core_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_buf_level", buf_level, 0);
        check("rst_s_ready", s_ready, 1);

        for (int i = 0; i < 2; i++) run_vec(i);

        // 64th sample completes the frame: first write two cycles after acceptance.
        push_n(1, 10, acc);
        wait_wr(5, k);
        check("t2_latency", k, 2);
        check("t2_wr_seen", core_wr, 1);
        repeat (68) @(negedge clk1);
        check("t2_frames", frame_cnt, 2);
        check("t2_level", buf_level, 0);
        release_core();
        check("t2_idle", busy, 0);

        for (int i = 2; i < 4; i++) run_vec(i);

        // Core keeps able2write high after the burst, then drops it for 200 cycles.
        wr0 = wr_total;
        repeat (3) @(negedge clk1);
        check("t4_hold_busy", busy, 1);
        able2write = 1'b0;
        push_n(64, 84, acc);
        repeat (136) @(negedge clk1);
        check("t4_acc", acc, 64);
        check("t4_level", buf_level, 128);
        check("t4_no_wr", wr_total - wr0, 0);
        check("t4_frames_held", frame_cnt, 3);
        check("t4_busy", busy, 1);
        able2write = 1'b1;
        wait_wr(10, k);
        check("t4_restart_latency", k, 3);
        repeat (70) @(negedge clk1);
        check("t4_frames", frame_cnt, 4);
        check("t4_level_after", buf_level, 64);
        release_core();
        repeat (70) @(negedge clk1);
        check("t4_frames_5", frame_cnt, 5);
        check("t4_level_drained", buf_level, 0);
        release_core();
        check("t4_idle", busy, 0);

        // Streaming at level 127: push and pop every burst cycle, pointers wrap.
        able2write = 1'b0;
        push_n(127, 147, acc);
        check("t5_fill", buf_level, 127);
        able2write = 1'b1;
        push_done  = 1'b0;
        fork
            begin
                int acc5;
                push_n(300, 2000, acc5);
                check("t5_acc", acc5, 300);
                push_done = 1'b1;
            end
            auto_core(3000);
            begin
                int kk;
                wait_wr(10, kk);
                repeat (10) @(negedge clk1);
                check("t5_level_steady", buf_level, 127);
            end
        join
        check("t5_frames", frame_cnt, 11);
        check("t5_level_left", buf_level, 43);
        check("t5_model_left", model_q.size(), 43);

        // Reset lands on beat 30 of a burst.
        able2write = 1'b1;
        push_n(21, 40, acc);
        beats = 0;
        k = 0;
        while (beats < 30 && k < 200) begin
            @(negedge clk1);
            if (core_wr === 1'b1) beats++;
            k++;
        end
        check("t6_reach_beat30", beats, 30);
        #1 rstn = 1'b0;
        #1;
        check("t6_core_wr_async", core_wr, 0);
        check("t6_core_data", core_data, 0);
        check("t6_level", buf_level, 0);
        check("t6_frames", frame_cnt, 0);
        check("t6_busy", busy, 0);
        repeat (2) @(negedge clk1);
        rstn = 1'b1;
        @(negedge clk1);
        check("t6_ready", s_ready, 1);
        check("t6_idle_wr", core_wr, 0);

        run_vec(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
